// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the RS485 burst transmitter: FSM state
//             encoding, parity-mode constants and the frame-length helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_DIRON  = 3'd1;
   localparam state_t S_SHIFT  = 3'd2;
   localparam state_t S_DIROFF = 3'd3;
   localparam state_t S_HOLD   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Bits per frame: start + data + optional parity + stop bits
   function automatic int frame_len(input int data_bits, input int parity_en,
                                    input int stop_bits);
      return 1 + data_bits + parity_en + stop_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_rs485_burst_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_rs485_burst_if
//  Purpose  : Bundle between the requester/frame buffer and the burst
//             transmitter.
//  Signals  : RQ    - transfer request (async to clk, level-held)
//             len   - words to send, latched at burst start
//             data  - buffer word at addr
//             addr  - buffer read address
//             tx    - serial line, idle high
//             dirTX - RS485 driver enable
//             dirRX - RS485 receiver-disable companion
//             busy  - transmitter not idle
//             done  - one-cycle pulse at burst completion
//  Modports : master = requester/buffer side, slave = transmitter
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_rs485_burst_if #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_W    = 5
);
   logic                 RQ;
   logic [ADDR_W-1:0]    len;
   logic [DATA_BITS-1:0] data;
   logic [ADDR_W-1:0]    addr;
   logic                 tx;
   logic                 dirTX;
   logic                 dirRX;
   logic                 busy;
   logic                 done;

   modport master (output RQ, len, data,
                   input  addr, tx, dirTX, dirRX, busy, done);
   modport slave  (input  RQ, len, data,
                   output addr, tx, dirTX, dirRX, busy, done);
endinterface
`default_nettype wire

// File: rtl/uart_tx_rs485_burst_ser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_ser
//  Purpose  : Serialises one UART frame per load strobe: start bit, data LSB
//             first, optional parity, stop bits. A new load on the last cycle
//             of a frame starts the next frame with no idle gap.
//  Ports    : clk, reset (async, active-low)
//             load      - start a frame (start bit appears next cycle)
//             data      - word, sampled in the first start-bit cycle
//             tx        - registered serial output, idle high
//             bit_stb   - last cycle of the current bit
//             bit_idx   - index of the current bit within the frame
//             frame_end - last cycle of the frame
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_ser
   import uart_pkg::*;
#(
   parameter  int DATA_BITS    = 8,
   parameter  int CLKS_PER_BIT = 1,
   parameter  int PARITY_EN    = 0,
   parameter  int PARITY_ODD   = 0,
   parameter  int STOP_BITS    = 1,
   localparam int FRAME_LEN    = frame_len(DATA_BITS, PARITY_EN, STOP_BITS),
   localparam int IDX_W        = $clog2(FRAME_LEN)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 bit_stb,
   output logic [IDX_W-1:0]     bit_idx,
   output logic                 frame_end
);
   localparam int TICK_W = $clog2(CLKS_PER_BIT + 1);

   logic                 active;
   logic [TICK_W-1:0]    tick;
   logic [IDX_W-1:0]     idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 tx_r;
   logic [DATA_BITS-1:0] word;
   logic [IDX_W-1:0]     next_idx;
   logic                 next_bit;
   logic                 first_cyc;
   logic                 par_mode;

   assign par_mode  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   assign first_cyc = (idx == '0) && (tick == '0);
   assign bit_stb   = active && (tick == TICK_W'(CLKS_PER_BIT - 1));
   assign frame_end = bit_stb && (idx == IDX_W'(FRAME_LEN - 1));
   // With one clock per bit, data bit 0 must be chosen in the same cycle the
   // word is captured, so bypass the shift register then.
   assign word      = first_cyc ? data : shreg;
   assign next_idx  = idx + IDX_W'(1);

   always_comb begin
      next_bit = 1'b1;
      for (int b = 0; b < DATA_BITS; b++) begin
         if (next_idx == IDX_W'(b + 1))
            next_bit = word[b];
      end
      if ((PARITY_EN != 0) && (next_idx == IDX_W'(DATA_BITS + 1)))
         next_bit = (^word) ^ par_mode;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active <= 1'b0;
         tick   <= '0;
         idx    <= '0;
         shreg  <= '0;
         tx_r   <= 1'b1;
      end else if (load) begin
         active <= 1'b1;
         tick   <= '0;
         idx    <= '0;
         tx_r   <= 1'b0;
      end else if (active) begin
         if (first_cyc)
            shreg <= data;
         if (bit_stb) begin
            tick <= '0;
            if (frame_end) begin
               active <= 1'b0;
               idx    <= '0;
               tx_r   <= 1'b1;
            end else begin
               idx  <= next_idx;
               tx_r <= next_bit;
            end
         end else begin
            tick <= tick + TICK_W'(1);
         end
      end
   end

   assign tx      = tx_r;
   assign bit_idx = idx;

endmodule
`default_nettype wire

// File: rtl/uart_tx_rs485_burst.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_rs485_burst
//  Purpose  : RS485 burst transmitter. Synchronises RQ, raises the direction
//             lines with guard delays, reads len words from the buffer and
//             sends them back to back as UART frames, then drops the
//             direction lines and waits for RQ to be released.
//  Ports    : clk   - bit-rate base clock
//             reset - asynchronous active-low reset
//             bus   - uart_tx_rs485_burst_if.slave (RQ, len, data, addr, tx,
//                     dirTX, dirRX, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_rs485_burst
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int ADDR_W       = 5,
   parameter int CLKS_PER_BIT = 1,
   parameter int DIR_DLY      = 15,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input logic                  clk,
   input logic                  reset,
   uart_tx_rs485_burst_if.slave bus
);
   localparam int         FRAME_LEN = frame_len(DATA_BITS, PARITY_EN, STOP_BITS);
   localparam int         IDX_W     = $clog2(FRAME_LEN);
   localparam logic [7:0] DLY_1     = 8'(DIR_DLY);
   localparam logic [7:0] DLY_2     = 8'(2 * DIR_DLY);
   localparam logic [7:0] DLY_3     = 8'(3 * DIR_DLY);

   logic              rq_meta;
   logic              rqs;
   state_t            state;
   logic [7:0]        dly;
   logic [ADDR_W-1:0] len_r;
   logic [ADDR_W-1:0] addr_r;
   logic              dir_tx_r;
   logic              dir_rx_r;
   logic              done_r;
   logic              ser_load;
   logic              ser_tx;
   logic              bit_stb;
   logic              frame_end;
   logic [IDX_W-1:0]  bit_idx;
   logic              last_word;

   // addr advances during the last stop bit, so at frame end it already
   // equals the number of words sent.
   assign last_word = (addr_r == len_r);
   assign ser_load  = ((state == S_DIRON) && (dly == DLY_3) && (len_r != '0)) ||
                      ((state == S_SHIFT) && frame_end && !last_word);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rq_meta <= 1'b0;
         rqs     <= 1'b0;
      end else begin
         rq_meta <= bus.RQ;
         rqs     <= rq_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         dly      <= '0;
         len_r    <= '0;
         addr_r   <= '0;
         dir_tx_r <= 1'b0;
         dir_rx_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rqs) begin
                  state  <= S_DIRON;
                  len_r  <= bus.len;
                  addr_r <= '0;
                  dly    <= '0;
               end
            end
            S_DIRON: begin
               dly <= dly + 8'd1;
               if (dly == DLY_1) dir_rx_r <= 1'b1;
               if (dly == DLY_2) dir_tx_r <= 1'b1;
               if (dly == DLY_3) begin
                  dly   <= '0;
                  state <= (len_r == '0) ? S_DIROFF : S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_stb && (bit_idx == IDX_W'(FRAME_LEN - 2)))
                  addr_r <= addr_r + ADDR_W'(1);
               if (frame_end && last_word) begin
                  addr_r <= '0;
                  dly    <= '0;
                  state  <= S_DIROFF;
               end
            end
            S_DIROFF: begin
               dly <= dly + 8'd1;
               if (dly == DLY_1) dir_tx_r <= 1'b0;
               if (dly == DLY_2) begin
                  dir_rx_r <= 1'b0;
                  done_r   <= 1'b1;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!rqs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   uart_frame_ser #(
      .DATA_BITS    (DATA_BITS),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .PARITY_EN    (PARITY_EN),
      .PARITY_ODD   (PARITY_ODD),
      .STOP_BITS    (STOP_BITS)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .data      (bus.data),
      .tx        (ser_tx),
      .bit_stb   (bit_stb),
      .bit_idx   (bit_idx),
      .frame_end (frame_end)
   );

   assign bus.tx    = ser_tx;
   assign bus.addr  = addr_r;
   assign bus.dirTX = dir_tx_r;
   assign bus.dirRX = dir_rx_r;
   assign bus.busy  = (state != S_IDLE);
   assign bus.done  = done_r;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_rs485_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_rs485_burst
//  Purpose  : Self-checking bench for uart_tx_rs485_burst. Four instances
//             cover 8N1/1clk, 8E2, 8N1/4clk and 8O2/2clk. A reference model
//             derives the expected line state for every cycle of a burst from
//             the frame rules and the guard delays.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_rs485_burst;
   localparam int NI = 4;
   localparam int AW = 5;
   localparam int DB = 8;
   localparam logic [9:0] IDLE_V = 10'b00_0010_0000;

   // Per-instance configuration, matching the instances below
   int cfg_dly [NI] = '{15, 5, 3, 2};
   int cfg_cpb [NI] = '{1, 1, 4, 2};
   int cfg_pe  [NI] = '{0, 1, 0, 1};
   int cfg_po  [NI] = '{0, 0, 0, 1};
   int cfg_sb  [NI] = '{1, 2, 1, 2};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NI-1:0] rq;
   logic [AW-1:0] len_v;
   logic [DB-1:0] mem [32];
   logic [9:0]    obs [NI];   // {busy, done, dirRX, dirTX, tx, addr}
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   uart_tx_rs485_burst_if #(.DATA_BITS(DB), .ADDR_W(AW)) bus0 ();
   uart_tx_rs485_burst_if #(.DATA_BITS(DB), .ADDR_W(AW)) bus1 ();
   uart_tx_rs485_burst_if #(.DATA_BITS(DB), .ADDR_W(AW)) bus2 ();
   uart_tx_rs485_burst_if #(.DATA_BITS(DB), .ADDR_W(AW)) bus3 ();

   uart_tx_rs485_burst dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
   uart_tx_rs485_burst #(.DIR_DLY(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
      dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
   uart_tx_rs485_burst #(.DIR_DLY(3), .CLKS_PER_BIT(4))
      dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
   uart_tx_rs485_burst #(.DIR_DLY(2), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1),
                         .STOP_BITS(2))
      dut3 (.clk(clk), .reset(rst_n), .bus(bus3));

   assign bus0.RQ = rq[0];  assign bus0.len = len_v;
   assign bus1.RQ = rq[1];  assign bus1.len = len_v;
   assign bus2.RQ = rq[2];  assign bus2.len = len_v;
   assign bus3.RQ = rq[3];  assign bus3.len = len_v;

   // Buffer with one cycle of read latency
   always @(posedge clk) begin
      bus0.data <= mem[bus0.addr];
      bus1.data <= mem[bus1.addr];
      bus2.data <= mem[bus2.addr];
      bus3.data <= mem[bus3.addr];
   end

   assign obs[0] = {bus0.busy, bus0.done, bus0.dirRX, bus0.dirTX, bus0.tx, bus0.addr};
   assign obs[1] = {bus1.busy, bus1.done, bus1.dirRX, bus1.dirTX, bus1.tx, bus1.addr};
   assign obs[2] = {bus2.busy, bus2.done, bus2.dirRX, bus2.dirTX, bus2.tx, bus2.addr};
   assign obs[3] = {bus3.busy, bus3.done, bus3.dirRX, bus3.dirTX, bus3.tx, bus3.addr};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Value of bit b of a frame carrying word w on instance i
   function automatic logic frame_bit(input logic [DB-1:0] w, input int b, input int i);
      if (b == 0) return 1'b0;
      if (b <= DB) return w[b-1];
      if ((cfg_pe[i] != 0) && (b == DB + 1)) return (^w) ^ (cfg_po[i] != 0);
      return 1'b1;
   endfunction

   // Expected {busy,done,dirRX,dirTX,tx,addr} at cycle k of an n-word burst,
   // k = 0 being the first cycle with busy high. dly is 0 in that cycle and a
   // direction line changes on the edge closing the cycle where dly hits its
   // threshold, so it is first seen one cycle later.
   function automatic logic [9:0] exp_vec(input int i, input int k, input int n);
      int d, c, fl, t_sh, t_off, t_hold, j, w, b;
      logic done_e, rx_e, dtx_e, tx_e;
      logic [AW-1:0] a_e;
      d      = cfg_dly[i];
      c      = cfg_cpb[i];
      fl     = 1 + DB + cfg_pe[i] + cfg_sb[i];
      t_sh   = 3 * d + 1;
      t_off  = t_sh + n * fl * c;
      t_hold = t_off + 2 * d + 1;
      done_e = (k == t_hold);
      rx_e   = (k >= d + 1) && (k < t_hold);
      dtx_e  = (k >= 2 * d + 1) && (k < t_off + d + 1);
      tx_e   = 1'b1;
      a_e    = '0;
      if (k >= t_sh && k < t_off) begin
         j    = k - t_sh;
         w    = j / (fl * c);
         b    = (j % (fl * c)) / c;
         tx_e = frame_bit(mem[w], b, i);
         a_e  = (b == fl - 1) ? AW'(w + 1) : AW'(w);
      end
      return {1'b1, done_e, rx_e, dtx_e, tx_e, a_e};
   endfunction

   // One burst on instance i. If abort_k >= 0, reset is pulsed at that cycle.
   task automatic burst(input int i, input int n, input int abort_k);
      int d, c, fl, t_hold, waitc;
      d      = cfg_dly[i];
      c      = cfg_cpb[i];
      fl     = 1 + DB + cfg_pe[i] + cfg_sb[i];
      t_hold = 3 * d + 1 + n * fl * c + 2 * d + 1;
      len_v  = AW'(n);
      rq[i]  = 1'b1;
      waitc  = 0;
      @(negedge clk);
      while (!obs[i][9] && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check($sformatf("start i%0d", i), 32'(obs[i][9]), 32'(1'b1));
      if (!obs[i][9]) begin
         rq[i] = 1'b0;
         return;
      end
      len_v = AW'($urandom);   // latched at entry, later changes are ignored
      for (int k = 0; k <= t_hold + 8; k++) begin
         check($sformatf("burst i%0d n%0d k%0d", i, n, k), 32'(obs[i]), 32'(exp_vec(i, k, n)));
         if (k == abort_k) begin
            #1 rst_n = 1'b0;
            #1;
            check($sformatf("abort i%0d", i), 32'(obs[i]), 32'(IDLE_V));
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
      end
      rq[i] = 1'b0;
      waitc = 0;
      while (obs[i][9] && waitc < 8) begin
         @(negedge clk);
         waitc++;
      end
      check($sformatf("release i%0d", i), 32'(obs[i]), 32'(IDLE_V));
      @(negedge clk);
      check($sformatf("gap i%0d", i), 32'(obs[i]), 32'(IDLE_V));
   endtask

   task automatic fill_random();
      for (int a = 0; a < 32; a++) mem[a] = DB'($urandom);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int i, n, fl0;
      rst_n = 1'b0;
      rq    = '0;
      len_v = '0;
      fill_random();
      repeat (2) @(negedge clk);
      for (int r = 0; r < NI; r++)
         check($sformatf("reset i%0d", r), 32'(obs[r]), 32'(IDLE_V));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Four known words, then the same burst again after RQ is cycled
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
      burst(0, 4, -1);
      burst(0, 4, -1);

      // Empty burst: direction lines only
      burst(0, 0, -1);

      // Parity frames, even and odd, two stop bits
      mem[0] = 8'h07;
      burst(1, 1, -1);
      burst(3, 1, -1);

      // Four clocks per bit
      mem[0] = 8'h01;
      burst(2, 1, -1);

      // Random words, lengths and instances
      for (int t = 0; t < 8; t++) begin
         fill_random();
         i = int'($urandom_range(0, NI - 1));
         n = int'($urandom_range(1, 6));
         burst(i, n, -1);
      end

      // Reset during data bit 3 of word 1, then a full restart with RQ high
      fill_random();
      fl0 = 1 + DB + cfg_pe[0] + cfg_sb[0];
      burst(0, 4, 3 * cfg_dly[0] + 1 + fl0 * cfg_cpb[0] + 4 * cfg_cpb[0]);
      burst(0, 4, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_rs485_burst.md
Name: uart_tx_rs485_burst

Overview:
Parametrised RS485 burst transmitter. On a request from another clock domain it asserts the transceiver direction lines with programmable guard delays, then reads `len` words from an external buffer through `addr` and serialises each word as a UART frame. The frame format is configurable: data width, optional parity, 1 or 2 stop bits, clocks per bit. Sits between the telemetry frame buffer and the RS485 line driver.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
ADDR_W, 5, buffer address / length width
CLKS_PER_BIT, 1, clk cycles per serial bit (1..255)
DIR_DLY, 15, guard delay in clk cycles between direction-line steps (1..63)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  bit-rate base clock
reset  in  1  asynchronous, active-low reset
RQ  in  1  transfer request, asynchronous to clk, level-held by requester
len  in  ADDR_W  number of words to send; sampled on IDLE->DIRON
data  in  DATA_BITS  buffer word at addr (1-cycle read latency allowed)
addr  out  ADDR_W  buffer read address (word index)
tx  out  1  serial line, idle high
dirTX  out  1  RS485 driver enable
dirRX  out  1  RS485 receiver-disable / DE companion
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on entry to HOLD

Behaviour:
- Reset (async, reset=0): state=IDLE, tx=1, dirTX=0, dirRX=0, addr=0, busy=0, done=0, all counters 0, RQ sync flops 0. Reset mid-frame aborts immediately with no stop-bit completion.
- RQ passes through a 2-flop synchroniser; `rqs` is the second flop. This adds 2 cycles of latency.
- States:
  - IDLE -> DIRON when rqs=1; latch len into len_r; addr=0; dly=0.
  - DIRON: dly increments each cycle. dirRX<=1 on the edge where dly==DIR_DLY. dirTX<=1 where dly==2*DIR_DLY. Go to SHIFT where dly==3*DIR_DLY. If len_r==0, go to DIROFF instead of SHIFT; dirs still rise and fall.
  - SHIFT: frames are emitted back to back with no idle gap between words.
    - Bit order: start(0), data[0..DATA_BITS-1], parity (if enabled), STOP_BITS stop bits (1).
    - Each bit lasts exactly CLKS_PER_BIT cycles.
    - data is captured into a shift register at the first cycle of the start bit. addr has been stable at least 1 cycle before that.
    - addr increments on the first cycle of the last stop bit.
    - After the last stop bit of word len_r-1: addr<=0, dly<=0, go to DIROFF.
  - DIROFF: dly increments. dirTX<=0 where dly==DIR_DLY. dirRX<=0 and go to HOLD where dly==2*DIR_DLY.
  - HOLD: done=1 for the entry cycle only. Go to IDLE when rqs=0. RQ still high means no retransmission.
- Parity: even parity = XOR of data bits; odd parity = inverted XOR.
- Counters:
  - bit-time counter width is ceil(log2(CLKS_PER_BIT+1)); wraps to 0 at CLKS_PER_BIT-1.
  - bit index counter is sized for DATA_BITS+PARITY_EN+STOP_BITS+1.
  - dly is 8 bits; DIR_DLY*3 must be <256.
- addr wraps naturally; len_r==2^ADDR_W is not representable, so max burst is 2^ADDR_W-1.
- RQ toggling during DIRON/SHIFT/DIROFF is ignored.
- tx is registered and glitch-free; tx=1 outside SHIFT.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, DIRON, SHIFT, DIROFF, HOLD), parity-mode constants, frame-length function (1+DATA_BITS+PARITY_EN+STOP_BITS).
- One natural sub-module: uart_frame_ser. It takes a word plus a load strobe and produces tx, bit-strobe and frame_end; it owns the bit-time counter, bit index and parity.
- The top owns the sync flops, the direction sequencing, the burst counter and addr.

Test Plan:
1. Defaults, len=4, words 0xA5,0x3C,0xFF,0x00, RQ high -> dirRX rises 15 cycles after DIRON entry and dirTX at 30. Then 40 tx bits in four 10-bit frames, e.g. 0xA5 = 0,1,0,1,0,0,1,0,1,1. addr steps 0..3. dirTX falls 15 and dirRX 30 cycles after the last stop bit. done pulses once.
2. RQ held high after done -> no second burst. Drop RQ, raise again -> second identical burst. busy is low for at least 1 cycle between the bursts.
3. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, len=1, word 0x07 -> tx = 0,1,1,1,0,0,0,0,0,1(parity),1,1. With PARITY_ODD=1 the parity bit is 0.
4. CLKS_PER_BIT=4, len=1, word 0x01 -> each bit exactly 4 cycles; frame is 40 cycles from start-bit falling edge to end of stop bit.
5. len=0 -> dirRX/dirTX rise and fall on schedule, tx stays 1 throughout, done pulses, addr stays 0.
6. reset=0 asserted during data bit 3 of word 1 -> same cycle: tx=1, dirTX=0, dirRX=0, addr=0, busy=0. After release with RQ still high, a full burst restarts from addr 0.
